// File: rtl/usb_in_controller_if.sv
// Bundle of the token-decoder, FIFO read-side and transmitter signals seen by
// the USB IN sequencer. The master modport is the sequencer's view; the slave
// modport is the view of the surrounding receiver/FIFO/transmitter.
interface usb_in_controller_if #(
   parameter int COUNT_W = 12
);
   logic               token_valid;
   logic [3:0]         rx_pid;
   logic [6:0]         rx_addr;
   logic [COUNT_W-1:0] fifo_count;
   logic [7:0]         fifo_rdata;
   logic               fifo_r_en;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_last;
   logic               tx_ack;
   logic               tx_busy;
   logic               is_txing;
   logic               toggle;

   modport master (
      input  token_valid, rx_pid, rx_addr, fifo_count, fifo_rdata, tx_ack, tx_busy,
      output fifo_r_en, tx_data, tx_valid, tx_last, is_txing, toggle
   );

   modport slave (
      output token_valid, rx_pid, rx_addr, fifo_count, fifo_rdata, tx_ack, tx_busy,
      input  fifo_r_en, tx_data, tx_valid, tx_last, is_txing, toggle
   );
endinterface

// File: rtl/usb_in_controller.sv
// USB IN-token sequencer for the Ethernet-to-USB bridge. Answers matching IN
// tokens with NAK when less than one payload is buffered, otherwise sends
// DATA0/DATA1 + MAX_PAYLOAD bytes from the FIFO + CRC16, then waits for the
// host ACK before advancing the data toggle.
module usb_in_controller #(
   parameter int         MAX_PAYLOAD = 64,
   parameter logic [6:0] DEV_ADDR    = 7'h4C,
   parameter int         ACK_TIMEOUT = 1024,
   parameter int         COUNT_W     = 12
) (
   input  logic               clk,
   input  logic               n_rst,
   usb_in_controller_if.master bus
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_NAK      = 3'd1;
   localparam logic [2:0] S_PID      = 3'd2;
   localparam logic [2:0] S_DATA     = 3'd3;
   localparam logic [2:0] S_CRC_LO   = 3'd4;
   localparam logic [2:0] S_CRC_HI   = 3'd5;
   localparam logic [2:0] S_DRAIN    = 3'd6;
   localparam logic [2:0] S_WAIT_ACK = 3'd7;

   localparam logic [3:0] PID_IN  = 4'b1001;
   localparam logic [3:0] PID_ACK = 4'b0010;

   localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

   logic [2:0]       state;
   logic             drain_to_wait;
   logic [7:0]       tx_data_q;
   logic             tx_valid_q;
   logic             tx_last_q;
   logic             toggle_q;
   logic [15:0]      crc;
   logic [CNT_W-1:0] byte_cnt;
   logic [TMR_W-1:0] timer;

   logic             xfer;
   logic             in_match;
   logic             ack_tok;
   logic             last_byte;
   logic [15:0]      crc_next;

   // Reflected USB CRC16 (0xA001), one byte processed LSB first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int unsigned i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // Decode handshake conditions and next CRC for the byte being accepted.
   always_comb begin
      xfer      = tx_valid_q & bus.tx_ack;
      in_match  = bus.token_valid && (bus.rx_pid == PID_IN) && (bus.rx_addr == DEV_ADDR);
      ack_tok   = bus.token_valid && (bus.rx_pid == PID_ACK);
      last_byte = (byte_cnt == CNT_W'(MAX_PAYLOAD - 1));
      crc_next  = crc16_byte(crc, bus.fifo_rdata);
   end

   // Payload bytes pass straight from the show-ahead head so the next byte is
   // on tx_data the cycle after a pop; every other byte comes from tx_data_q.
   assign bus.tx_data   = (state == S_DATA) ? bus.fifo_rdata : tx_data_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_last   = tx_last_q;
   assign bus.fifo_r_en = bus.tx_ack & (state == S_DATA);
   assign bus.is_txing  = (state != S_IDLE) && (state != S_WAIT_ACK);
   assign bus.toggle    = toggle_q;

   // Packet sequencer: state, registered transmit outputs, CRC, toggle, timer.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= S_IDLE;
         drain_to_wait <= 1'b0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         tx_last_q     <= 1'b0;
         toggle_q      <= 1'b1;
         crc           <= '1;
         byte_cnt      <= '0;
         timer         <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_match) begin
                  tx_valid_q <= 1'b1;
                  if (bus.fifo_count < COUNT_W'(MAX_PAYLOAD)) begin
                     state     <= S_NAK;
                     tx_data_q <= 8'h5A;
                     tx_last_q <= 1'b1;
                  end else begin
                     state     <= S_PID;
                     tx_data_q <= toggle_q ? 8'h4B : 8'hC3;
                     tx_last_q <= 1'b0;
                     crc       <= '1;
                     byte_cnt  <= '0;
                  end
               end
            end
            S_NAK: begin
               if (xfer) begin
                  state         <= S_DRAIN;
                  drain_to_wait <= 1'b0;
                  tx_valid_q    <= 1'b0;
                  tx_last_q     <= 1'b0;
                  tx_data_q     <= '0;
               end
            end
            S_PID: begin
               if (xfer) state <= S_DATA;
            end
            S_DATA: begin
               if (xfer) begin
                  crc      <= crc_next;
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  if (last_byte) begin
                     state     <= S_CRC_LO;
                     tx_data_q <= ~crc_next[7:0];
                  end
               end
            end
            S_CRC_LO: begin
               if (xfer) begin
                  state     <= S_CRC_HI;
                  tx_data_q <= ~crc[15:8];
                  tx_last_q <= 1'b1;
               end
            end
            S_CRC_HI: begin
               if (xfer) begin
                  state         <= S_DRAIN;
                  drain_to_wait <= 1'b1;
                  tx_valid_q    <= 1'b0;
                  tx_last_q     <= 1'b0;
                  tx_data_q     <= '0;
               end
            end
            S_DRAIN: begin
               if (!bus.tx_busy) begin
                  state <= drain_to_wait ? S_WAIT_ACK : S_IDLE;
                  timer <= '0;
               end
            end
            S_WAIT_ACK: begin
               if (ack_tok) begin
                  toggle_q <= ~toggle_q;
                  state    <= S_IDLE;
               end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                  state <= S_IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
